// File: rtl/seg_counter_display.sv
// Multi-digit BCD/hex up/down counter with a multiplexed 7-segment display driver.
// Two free-running dividers share clk_in: one produces count ticks, the other
// steps the digit scan. The counter value is exported directly. Digit enables
// and segments are registered, so they trail the scan index and value by one cycle.
module seg_counter_display #(
    parameter int NUM_DIGITS = 4,
    parameter int COUNT_DIV  = 50_000_000,
    parameter int SCAN_DIV   = 250_000,
    parameter int HEX_MODE   = 0,
    parameter int BLANK_LZ   = 0
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      cnt_en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [NUM_DIGITS-1:0]     cc,
    output logic [7:0]                seg_out,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic                      wrap
);

    localparam int         VW   = 4 * NUM_DIGITS;
    localparam int         CW   = $clog2(COUNT_DIV);
    localparam int         SW   = $clog2(SCAN_DIV);
    localparam int         IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] DMAX = (HEX_MODE != 0) ? 4'hF : 4'h9;

    logic [CW-1:0]         cnt_div;
    logic [SW-1:0]         scan_div;
    logic [IW-1:0]         scan_idx;
    logic                  cnt_tick;
    logic                  scan_tick;
    logic [VW-1:0]         value_q;
    logic                  wrap_q;
    logic [NUM_DIGITS-1:0] cc_q;
    logic [7:0]            seg_q;

    logic [VW-1:0]         step_val;
    logic                  step_carry;
    logic [VW-1:0]         load_clean;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] cc_d;
    logic [3:0]            cur_digit;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [7:0]            seg_d;

    assign cnt_tick  = (cnt_div == CW'(COUNT_DIV - 1));
    assign scan_tick = (scan_div == SW'(SCAN_DIV - 1));

    assign value   = value_q;
    assign wrap    = wrap_q;
    assign cc      = cc_q;
    assign seg_out = seg_q;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Count divider: 0..COUNT_DIV-1, tick on the terminal value.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)        cnt_div <= '0;
        else if (cnt_tick) cnt_div <= '0;
        else               cnt_div <= cnt_div + 1'b1;
    end

    // Scan divider and digit index; independent of the count divider.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            scan_div <= '0;
            scan_idx <= '0;
        end else if (scan_tick) begin
            scan_div <= '0;
            scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_div <= scan_div + 1'b1;
        end
    end

    // Ripple +/-1 across digits; a carry out of the top digit means wrap-around.
    always_comb begin
        step_val   = value_q;
        step_carry = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (step_carry) begin
                if (up_dn) begin
                    if (value_q[4*k +: 4] == DMAX) begin
                        step_val[4*k +: 4] = 4'h0;
                    end else begin
                        step_val[4*k +: 4] = value_q[4*k +: 4] + 4'h1;
                        step_carry         = 1'b0;
                    end
                end else begin
                    if (value_q[4*k +: 4] == 4'h0) begin
                        step_val[4*k +: 4] = DMAX;
                    end else begin
                        step_val[4*k +: 4] = value_q[4*k +: 4] - 4'h1;
                        step_carry         = 1'b0;
                    end
                end
            end
        end
    end

    // In BCD mode, out-of-range load digits are stored as zero.
    always_comb begin
        load_clean = load_val;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((HEX_MODE == 0) && (load_val[4*k +: 4] > 4'd9)) load_clean[4*k +: 4] = 4'h0;
        end
    end

    // Counter value and wrap pulse; load takes priority and never wraps.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= !load && cnt_tick && cnt_en && step_carry;
            if (load)                  value_q <= load_clean;
            else if (cnt_tick && cnt_en) value_q <= step_val;
        end
    end

    // Pick the scanned digit, its dp bit, and whether it is a blanked leading zero.
    always_comb begin
        upper_zero = '0;
        cc_d       = '0;
        cur_digit  = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (k == NUM_DIGITS - 1) upper_zero[k] = (value_q[4*k +: 4] == 4'h0);
            else                     upper_zero[k] = upper_zero[k+1] && (value_q[4*k +: 4] == 4'h0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            cc_d[NUM_DIGITS-1-k] = (scan_idx == IW'(k));
            if (scan_idx == IW'(k)) begin
                cur_digit = value_q[4*k +: 4];
                cur_dp    = dp_mask[k];
                cur_blank = (BLANK_LZ != 0) && (k != 0) && upper_zero[k];
            end
        end
        seg_d = {cur_dp, cur_blank ? 7'h00 : glyph(cur_digit)};
    end

    // Registered display outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cc_q  <= '0;
            seg_q <= '0;
        end else begin
            cc_q  <= cc_d;
            seg_q <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_counter_display.sv
// Bench for seg_counter_display: a BCD instance without blanking and a hex
// instance with leading-zero blanking share one stimulus stream. An integer
// reference model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_seg_counter_display;

  localparam int N         = 4;
  localparam int COUNT_DIV = 4;
  localparam int SCAN_DIV  = 2;

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [3:0] CC_SEQ [8]  = '{4'b1000, 4'b1000, 4'b0100, 4'b0100,
                                         4'b0010, 4'b0010, 4'b0001, 4'b0001};
  localparam logic [7:0] SEG_A39 [8] = '{8'h3F, 8'h3F, 8'hE6, 8'hE6, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
  localparam logic [7:0] SEG_B39 [8] = '{8'h3F, 8'h3F, 8'hE6, 8'hE6, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    int         v;
    logic       w;
    logic [3:0] cc;
    logic [7:0] seg;
  } mstate_t;

  // clock / reset / stimulus signals
  logic          clk_in = 1'b0;
  logic          rst_n;
  logic          cnt_en;
  logic          up_dn;
  logic          load;
  logic [15:0]   load_val;
  logic [N-1:0]  dp_mask;
  logic [N-1:0]  cc_a, cc_b;
  logic [7:0]    seg_a, seg_b;
  logic [15:0]   value_a, value_b;
  logic          wrap_a, wrap_b;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  mstate_t ms_a = '{v: 0, w: 1'b0, cc: 4'h0, seg: 8'h00};
  mstate_t ms_b = '{v: 0, w: 1'b0, cc: 4'h0, seg: 8'h00};

  always #5 clk_in = ~clk_in;

  seg_counter_display #(.NUM_DIGITS(N), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV),
                        .HEX_MODE(0), .BLANK_LZ(0)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .dp_mask(dp_mask), .cc(cc_a), .seg_out(seg_a),
    .value(value_a), .wrap(wrap_a)
  );

  seg_counter_display #(.NUM_DIGITS(N), .COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV),
                        .HEX_MODE(1), .BLANK_LZ(1)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .dp_mask(dp_mask), .cc(cc_b), .seg_out(seg_b),
    .value(value_b), .wrap(wrap_b)
  );

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  function automatic logic [15:0] to_nibbles(input int v, input int base);
    logic [15:0] r = '0;
    for (int k = 0; k < N; k++) r[4*k +: 4] = 4'((v / ipow(base, k)) % base);
    return r;
  endfunction

  // One clock edge of the reference: the counter is an integer modulo base^N,
  // the display shows digit (n/SCAN_DIV)%N of the pre-edge value.
  function automatic mstate_t step_model(input mstate_t s, input int base, input bit blank,
                                         input int n, input logic en, input logic up,
                                         input logic ld, input logic [15:0] lv,
                                         input logic [N-1:0] dp);
    mstate_t r;
    int lim   = ipow(base, N);
    int idx   = (n / SCAN_DIV) % N;
    int digit = (s.v / ipow(base, idx)) % base;
    int lval  = 0;
    bit tick  = (n % COUNT_DIV) == (COUNT_DIV - 1);
    r.cc       = 4'(1 << (N - 1 - idx));
    r.seg[6:0] = (blank && idx > 0 && s.v < ipow(base, idx)) ? 7'h00 : GLYPH[digit];
    r.seg[7]   = dp[idx];
    for (int k = 0; k < N; k++) begin
      int d = int'(lv[4*k +: 4]);
      if (d >= base) d = 0;
      lval += d * ipow(base, k);
    end
    if (ld) begin
      r.v = lval;
      r.w = 1'b0;
    end else if (tick && en) begin
      if (up) begin
        r.w = (s.v == lim - 1);
        r.v = (s.v + 1) % lim;
      end else begin
        r.w = (s.v == 0);
        r.v = (s.v + lim - 1) % lim;
      end
    end else begin
      r.v = s.v;
      r.w = 1'b0;
    end
    return r;
  endfunction

  // reference model state
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      edge_n <= 0;
      ms_a   <= '{v: 0, w: 1'b0, cc: 4'h0, seg: 8'h00};
      ms_b   <= '{v: 0, w: 1'b0, cc: 4'h0, seg: 8'h00};
    end else begin
      ms_a   <= step_model(ms_a, 10, 1'b0, edge_n, cnt_en, up_dn, load, load_val, dp_mask);
      ms_b   <= step_model(ms_b, 16, 1'b1, edge_n, cnt_en, up_dn, load, load_val, dp_mask);
      edge_n <= edge_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every output of both instances against the model each cycle
  always @(negedge clk_in) begin
    check("model value_a", 32'(value_a), 32'(to_nibbles(ms_a.v, 10)));
    check("model wrap_a",  32'(wrap_a),  32'(ms_a.w));
    check("model cc_a",    32'(cc_a),    32'(ms_a.cc));
    check("model seg_a",   32'(seg_a),   32'(ms_a.seg));
    check("model value_b", 32'(value_b), 32'(to_nibbles(ms_b.v, 16)));
    check("model wrap_b",  32'(wrap_b),  32'(ms_b.w));
    check("model cc_b",    32'(cc_b),    32'(ms_b.cc));
    check("model seg_b",   32'(seg_b),   32'(ms_b.seg));
  end

  // Wait (bounded) until the next clock edge index has the given phase.
  task automatic wait_phase(input int m, input int r);
    int guard = 0;
    while ((edge_n % m) != r && guard < 16) begin
      @(negedge clk_in);
      guard++;
    end
    if ((edge_n % m) != r) begin
      checks++;
      errors++;
      $display("FAIL phase wait: got %0d expected %0d", edge_n % m, r);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk_in);
    load = 1'b0;
  endtask

  initial begin
    cnt_en   = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    dp_mask  = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset value_a", 32'(value_a), 32'h0);
    check("reset cc_a",    32'(cc_a),    32'h0);
    check("reset seg_a",   32'(seg_a),   32'h0);
    check("reset wrap_a",  32'(wrap_a),  32'h0);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("first cc_a",  32'(cc_a),  32'h8);
    check("first seg_a", 32'(seg_a), 32'h3F);
    check("first seg_b", 32'(seg_b), 32'h3F);

    // BCD up through 9999 to wrap
    wait_phase(COUNT_DIV, 0);
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    do_load(16'h9998);
    repeat (3) @(negedge clk_in);
    check("up 9999 value_a", 32'(value_a), 32'h9999);
    check("up 9999 wrap_a",  32'(wrap_a),  32'h0);
    check("up 9999 value_b", 32'(value_b), 32'h9999);
    repeat (4) @(negedge clk_in);
    check("up wrap value_a", 32'(value_a), 32'h0000);
    check("up wrap wrap_a",  32'(wrap_a),  32'h1);
    check("up hex value_b",  32'(value_b), 32'h999A);
    check("up hex wrap_b",   32'(wrap_b),  32'h0);
    @(negedge clk_in);
    check("wrap pulse end", 32'(wrap_a), 32'h0);

    // down-count wrap from zero, then a BCD-invalid load
    wait_phase(COUNT_DIV, 0);
    up_dn = 1'b0;
    do_load(16'h0000);
    repeat (3) @(negedge clk_in);
    check("down value_a", 32'(value_a), 32'h9999);
    check("down wrap_a",  32'(wrap_a),  32'h1);
    check("down value_b", 32'(value_b), 32'hFFFF);
    check("down wrap_b",  32'(wrap_b),  32'h1);
    cnt_en = 1'b0;
    do_load(16'h00AF);
    check("bad bcd load a", 32'(value_a), 32'h0000);
    check("hex load b",     32'(value_b), 32'h00AF);

    // hex carry chain without wrap, then the scan sequence
    wait_phase(COUNT_DIV, 0);
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    do_load(16'h0FFF);
    repeat (3) @(negedge clk_in);
    check("hex carry value_b", 32'(value_b), 32'h1000);
    check("hex carry wrap_b",  32'(wrap_b),  32'h0);
    check("bcd carry value_a", 32'(value_a), 32'h0001);
    cnt_en = 1'b0;
    wait_phase(2 * N, 0);
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk_in);
      check("scan cc_b", 32'(cc_b), 32'(CC_SEQ[i]));
    end

    // leading-zero blanking with a decimal point on digit 1
    dp_mask = 4'b0010;
    do_load(16'h0040);
    wait_phase(2 * N, 0);
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk_in);
      check("blank seg_b", 32'(seg_b), 32'(SEG_B39[i]));
      check("noblank seg_a", 32'(seg_a), 32'(SEG_A39[i]));
    end
    dp_mask = '0;

    // load coincident with a count tick, then disabled counting
    wait_phase(COUNT_DIV, COUNT_DIV - 1);
    cnt_en = 1'b1;
    up_dn  = 1'b1;
    do_load(16'h1234);
    check("load on tick value_a", 32'(value_a), 32'h1234);
    check("load on tick wrap_a",  32'(wrap_a),  32'h0);
    check("load on tick value_b", 32'(value_b), 32'h1234);
    cnt_en = 1'b0;
    repeat (3 * COUNT_DIV) @(negedge clk_in);
    check("hold value_a", 32'(value_a), 32'h1234);

    // asynchronous reset mid-scan
    do_load(16'h0567);
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("async value_a", 32'(value_a), 32'h0);
    check("async cc_a",    32'(cc_a),    32'h0);
    check("async seg_a",   32'(seg_a),   32'h0);
    check("async value_b", 32'(value_b), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("post reset cc_a",  32'(cc_a),  32'h8);
    check("post reset seg_a", 32'(seg_a), 32'h3F);
    check("post reset seg_b", 32'(seg_b), 32'h3F);

    // randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_in);
      cnt_en  = ($urandom_range(0, 3) != 0);
      up_dn   = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 15) == 0);
      dp_mask = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: load_val = 16'($urandom);
        1: load_val = 16'h9999;
        2: load_val = 16'hFFFF;
        default: load_val = 16'h0000;
      endcase
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
      end
    end
    load = 1'b0;
    @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_counter_display.md
SEG_COUNTER_DISPLAY -- requirements
Module: seg_counter_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of counter and display digits, legal range 1..8.
REQ-002 Parameter COUNT_DIV, default 50_000_000, input clocks per count tick, minimum 2.
REQ-003 Parameter SCAN_DIV, default 250_000, input clocks per digit-scan step, minimum 2.
REQ-004 Parameter HEX_MODE, default 0; 0 selects BCD digits (0..9), 1 selects hex digits (0..F).
REQ-005 Parameter BLANK_LZ, default 0; 1 enables leading-zero blanking.
REQ-006 clk_in  input  1  single clock; all logic SHALL be on its rising edge, with no derived clocks.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 cnt_en  input  1  count enable, sampled on count ticks.
REQ-009 up_dn  input  1  count direction; 1 counts up, 0 counts down.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  4*NUM_DIGITS  load value; digit k occupies bits [4k+3:4k], and digit 0 is least significant.
REQ-012 dp_mask  input  NUM_DIGITS  decimal point enable per digit.
REQ-013 cc  output  NUM_DIGITS  one-hot digit enable, active-high; digit k drives cc[NUM_DIGITS-1-k].
REQ-014 seg_out  output  8  segments, active-high; bit0..bit6 = a..g, bit7 = dp.
REQ-015 value  output  4*NUM_DIGITS  current counter value.
REQ-016 wrap  output  1  one-cycle pulse on counter wrap-around.

Function
REQ-017 The count divider SHALL count 0..COUNT_DIV-1 and assert an internal count tick for exactly one cycle when it equals COUNT_DIV-1, then return to 0.
REQ-018 The scan divider SHALL behave identically with SCAN_DIV and run independently of the count divider.
REQ-019 On a cycle with load=1, value SHALL take load_val at the next edge, regardless of the count tick or cnt_en; the count divider continues unaffected.
REQ-020 In BCD mode, any loaded digit greater than 9 SHALL be stored as 0.
REQ-021 On a count tick with load=0 and cnt_en=1, value SHALL step by 1 in the up_dn direction at that edge, using multi-digit BCD or hex carry/borrow.
REQ-022 Up-count at the all-maximum value (9..9 or F..F) SHALL wrap to all-zero and pulse wrap on the same edge.
REQ-023 Down-count at all-zero SHALL wrap to all-maximum and pulse wrap on the same edge.
REQ-024 A count tick with cnt_en=0 SHALL leave value unchanged and wrap low.
REQ-025 Load SHALL never assert wrap.
REQ-026 The scan index SHALL advance 0,1,...,NUM_DIGITS-1,0 on each scan tick.
REQ-027 cc and seg_out SHALL be registered, reflecting the scan index and value from the previous cycle (1-cycle latency).
REQ-028 Exactly one cc bit SHALL be high at all times after the first post-reset edge.
REQ-029 seg_out[6:0] SHALL use the glyphs 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71 (hex).
REQ-030 seg_out[7] SHALL equal dp_mask[k] for the displayed digit k.
REQ-031 With BLANK_LZ=1, digit k>0 SHALL show seg_out[6:0]=0 when digits k..NUM_DIGITS-1 are all zero.
REQ-032 Leading-zero blanking SHALL leave dp and cc unaffected, and digit 0 SHALL never be blanked.

Reset
REQ-033 While rst_n=0, value=0, wrap=0, cc=0, seg_out=0, both dividers=0, and scan index=0.
REQ-034 The first edge after reset release SHALL drive cc to select digit 0 (cc=1000 for 4 digits) with the glyph for 0.
REQ-035 Reset asserted mid-count or mid-scan SHALL clear all state immediately, without waiting for a clock edge.

Verification (NUM_DIGITS=4, COUNT_DIV=4, SCAN_DIV=2)
REQ-036 BCD, cnt_en=1, up_dn=1, load 0x9998 -> value 9999 after the next count tick, then 0000 with wrap=1 for one cycle on the following tick.
REQ-037 BCD down-count from 0000 -> 9999 with a wrap pulse; load 0x00AF -> value 0x0000.
REQ-038 HEX_MODE=1, load 0x0FFF, up-count -> 0x1000 with no wrap; cc sequence 1000,0100,0010,0001 repeats every 8 clocks.
REQ-039 BLANK_LZ=1, value 0x0040, dp_mask=0010 -> digit1 shows 66 with dp; digit0 shows 3F; digits 2 and 3 show seg_out=00.
REQ-040 load=1 coincident with a count tick, load_val 0x1234 -> value 1234 with wrap=0; cnt_en=0 across 3 ticks -> value stays 1234.
REQ-041 rst_n pulsed low mid-scan at value 0x0567 -> all outputs 0 asynchronously; after release, cc=1000 and seg_out=3F.
